// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: one DIGIT-bit slice reused over WIDTH/DIGIT cycles,
// with valid/ready handshakes on both the operand and result sides.
module digit_serial_adder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned N    = WIDTH / DIGIT;
    localparam int unsigned CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    // Reject parameter combinations that cannot be split into whole digits
    if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
        $error("digit_serial_adder: DIGIT must divide WIDTH and lie in 1..WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_d;
    logic             carry_q, carry_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             cout_d, ovf_d;
    logic             in_ready_d, out_valid_d;
    logic [DIGIT:0]   slice;

    // The single shared DIGIT-bit adder slice
    assign slice = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + (DIGIT+1)'(carry_q);

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_d    = sum;
        carry_d  = carry_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        cout_d   = cout;
        ovf_d    = overflow;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = sub ? ~b[WIDTH-1] : b[WIDTH-1];
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // LSB digit first: new digit enters at the top, register shifts right
                sum_d   = WIDTH'({slice[DIGIT-1:0], sum} >> DIGIT);
                carry_d = slice[DIGIT];
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    cout_d  = slice[DIGIT];
                    ovf_d   = (a_msb_q == b_msb_q) && (slice[DIGIT-1] != a_msb_q);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            carry_q   <= 1'b0;
            a_msb_q   <= 1'b0;
            b_msb_q   <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            carry_q   <= carry_d;
            a_msb_q   <= a_msb_d;
            b_msb_q   <= b_msb_d;
            sum       <= sum_d;
            cout      <= cout_d;
            overflow  <= ovf_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: directed 8-bit/2-digit cases plus random sweeps
// of 32-bit instances with DIGIT = 1, 4, 32 against an arithmetic reference.
module tb_digit_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a, b;
    logic        cin, sub;

    // 8-bit, 2-bit-digit instance
    logic       iv8, ir8, ov8, ordy8, cout8, ovf8;
    logic [7:0] sum8;

    // 32-bit instances: index 0 -> DIGIT 1, 1 -> DIGIT 4, 2 -> DIGIT 32
    logic        iv   [3];
    logic        ir   [3];
    logic        ov   [3];
    logic        ordy [3];
    logic [31:0] sm   [3];
    logic        co   [3];
    logic        of   [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    digit_serial_adder #(.WIDTH(8), .DIGIT(2)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv8),
        .in_ready  (ir8),
        .a         (a[7:0]),
        .b         (b[7:0]),
        .cin       (cin),
        .sub       (sub),
        .out_valid (ov8),
        .out_ready (ordy8),
        .sum       (sum8),
        .cout      (cout8),
        .overflow  (ovf8)
    );

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned D = (g == 0) ? 1 : ((g == 1) ? 4 : 32);
        digit_serial_adder #(.WIDTH(32), .DIGIT(D)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (iv[g]),
            .in_ready  (ir[g]),
            .a         (a),
            .b         (b),
            .cin       (cin),
            .sub       (sub),
            .out_valid (ov[g]),
            .out_ready (ordy[g]),
            .sum       (sm[g]),
            .cout      (co[g]),
            .overflow  (of[g])
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer add/sub, with signed range test for overflow
    function automatic void model(input int w, input logic [31:0] xa, input logic [31:0] xb,
                                  input logic xc, input logic xs,
                                  output logic [31:0] es, output logic ec, output logic eo);
        longint lim, ua, ub, sa, sb, r, sr;
        lim = longint'(1) << w;
        ua  = longint'(xa) & (lim - 1);
        ub  = longint'(xb) & (lim - 1);
        sa  = (ua >= lim / 2) ? ua - lim : ua;
        sb  = (ub >= lim / 2) ? ub - lim : ub;
        if (xs) begin
            r  = ua - ub;
            sr = sa - sb;
            ec = (ua >= ub);
        end else begin
            r  = ua + ub + longint'(xc);
            sr = sa + sb + longint'(xc);
            ec = (r >= lim);
        end
        es = 32'(r & (lim - 1));
        eo = (sr < -(lim / 2)) || (sr >= lim / 2);
    endfunction

    // One full transaction on the 8-bit instance with constant expectations
    task automatic op8(input string tag, input logic [7:0] xa, input logic [7:0] xb,
                       input logic xc, input logic xs,
                       input logic [7:0] es, input logic ec, input logic eo);
        int guard, lat;
        a = {24'h0, xa}; b = {24'h0, xb}; cin = xc; sub = xs; iv8 = 1'b1;
        guard = 0;
        while (!ir8 && guard < 10) begin tick(); guard++; end
        chk({tag, "_ready"}, 64'(ir8), 64'(1));
        tick();
        iv8 = 1'b0; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; cin = ~xc; sub = ~xs;
        chk({tag, "_busy"}, 64'(ir8), 64'(0));
        lat = 0;
        while (!ov8 && lat < 8) begin tick(); lat++; end
        chk({tag, "_lat"}, 64'(lat), 64'(4));
        chk({tag, "_sum"}, 64'(sum8), 64'(es));
        chk({tag, "_cout"}, 64'(cout8), 64'(ec));
        chk({tag, "_ovf"}, 64'(ovf8), 64'(eo));
        ordy8 = 1'b1;
        tick();
        ordy8 = 1'b0;
        chk({tag, "_idle"}, 64'({ir8, ov8}), 64'(2'b10));
    endtask

    // One random transaction on a 32-bit instance, random stall before taking result
    task automatic op32(input int g, input int n);
        logic [31:0] xa, xb, es;
        logic        xc, xs, ec, eo;
        int          guard, lat, stall;
        xa = $urandom; xb = $urandom;
        xc = 1'($urandom_range(0, 1)); xs = 1'($urandom_range(0, 1));
        model(32, xa, xb, xc, xs, es, ec, eo);
        a = xa; b = xb; cin = xc; sub = xs; iv[g] = 1'b1;
        guard = 0;
        while (!ir[g] && guard < 10) begin tick(); guard++; end
        chk("sweep_ready", 64'(ir[g]), 64'(1));
        tick();
        iv[g] = 1'b0; a = $urandom; b = $urandom;
        cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
        lat = 0;
        while (!ov[g] && lat < n + 4) begin tick(); lat++; end
        chk($sformatf("sweep%0d_lat", g), 64'(lat), 64'(n));
        stall = $urandom_range(0, 3);
        repeat (stall) tick();
        chk($sformatf("sweep%0d_sum a=%h b=%h c=%b s=%b", g, xa, xb, xc, xs), 64'(sm[g]), 64'(es));
        chk($sformatf("sweep%0d_cout", g), 64'(co[g]), 64'(ec));
        chk($sformatf("sweep%0d_ovf", g), 64'(of[g]), 64'(eo));
        ordy[g] = 1'b1;
        tick();
        ordy[g] = 1'b0;
    endtask

    initial begin
        int lat, guard, nlat [3];
        logic seen;
        nlat[0] = 32; nlat[1] = 8; nlat[2] = 1;
        rst_n = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        iv8 = 1'b0; ordy8 = 1'b0;
        for (int i = 0; i < 3; i++) begin iv[i] = 1'b0; ordy[i] = 1'b0; end
        tick(); tick();
        rst_n = 1'b1;

        // Reset state
        chk("rst_in_ready", 64'(ir8), 64'(1));
        chk("rst_out_valid", 64'(ov8), 64'(0));
        chk("rst_sum", 64'(sum8), 64'(0));
        chk("rst_cout_ovf", 64'({cout8, ovf8}), 64'(0));
        chk("rst_ready32", 64'({ir[0], ir[1], ir[2]}), 64'(3'b111));

        // Directed 8-bit cases
        op8("add",  8'h5A, 8'h33, 1'b1, 1'b0, 8'h8E, 1'b0, 1'b1);
        op8("wrap", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        op8("sub1", 8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0);
        op8("sub2", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

        // Backpressure: result held while new operands wait
        a = 32'h12; b = 32'h34; cin = 1'b0; sub = 1'b0; iv8 = 1'b1;
        chk("bp_ready0", 64'(ir8), 64'(1));
        tick();
        a = 32'h70; b = 32'h10;
        lat = 0;
        while (!ov8 && lat < 8) begin tick(); lat++; end
        chk("bp_lat", 64'(lat), 64'(4));
        for (int i = 0; i < 6; i++) begin
            chk("bp_hold_ready", 64'(ir8), 64'(0));
            chk("bp_hold_valid", 64'(ov8), 64'(1));
            chk("bp_hold_out", 64'({sum8, cout8, ovf8}), 64'({8'h46, 1'b0, 1'b0}));
            tick();
        end
        ordy8 = 1'b1;
        tick();
        ordy8 = 1'b0;
        chk("bp_release", 64'({ir8, ov8}), 64'(2'b10));
        tick();
        iv8 = 1'b0;
        chk("bp_accept", 64'(ir8), 64'(0));
        lat = 0;
        while (!ov8 && lat < 8) begin tick(); lat++; end
        chk("bp2_lat", 64'(lat), 64'(4));
        chk("bp2_out", 64'({sum8, cout8, ovf8}), 64'({8'h80, 1'b0, 1'b1}));
        ordy8 = 1'b1;
        tick();
        ordy8 = 1'b0;

        // Reset during the second RUN cycle discards the operation
        a = 32'h0F; b = 32'h01; cin = 1'b0; sub = 1'b0; iv8 = 1'b1; ordy8 = 1'b1;
        guard = 0;
        while (!ir8 && guard < 10) begin tick(); guard++; end
        tick();
        iv8 = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_idle", 64'({ir8, ov8}), 64'(2'b10));
        chk("mid_rst_sum", 64'(sum8), 64'(0));
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin tick(); seen = seen | ov8; end
        chk("mid_rst_no_result", 64'(seen), 64'(0));
        ordy8 = 1'b0;

        // Random sweeps on 32-bit instances
        for (int g = 0; g < 3; g++) begin
            for (int k = 0; k < 1000; k++) begin
                op32(g, nlat[g]);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
